// File: rtl/instr_fetch_unit_if.sv
// Instruction memory read port: one word request at a time over a req/ack
// handshake. The fetch unit drives the request side through the master modport.
interface instr_fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;

    modport master (output imem_req, output imem_addr, input imem_ack, input imem_rdata);
    modport slave  (input imem_req, input imem_addr, output imem_ack, output imem_rdata);
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: holds the fetch PC and issues single outstanding
// word reads. A small prefetch FIFO feeds the classifier. Redirects flush
// the FIFO and drop any in-flight word.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst,
    instr_fetch_unit_if.master  imem,
    input  logic                redirect_valid,
    input  logic [31:0]         redirect_pc,
    input  logic                stall,
    output logic                instr_valid,
    output logic [31:0]         instruction,
    output logic [31:0]         instr_pc
);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {IDLE, REQ, DISCARD} state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } entry_t;

    state_e          state_q, state_d;
    logic [31:0]     fetch_pc_q, fetch_pc_d;
    logic            req_q, req_d;
    logic [31:0]     addr_q, addr_d;
    logic [CW-1:0]   count_q, count_d;
    entry_t          fifo_q [FIFO_DEPTH];
    entry_t          fifo_d [FIFO_DEPTH];

    logic            ack;
    logic            push;
    logic            pop;
    logic [CW-1:0]   count_after;
    logic            can_issue;
    logic [31:0]     redirect_pc_al;
    logic            unused_pc_lsb;

    // An ack only counts while a request is actually presented; stale acks
    // after reset or between requests are ignored.
    assign ack            = imem.imem_ack & req_q;
    assign pop            = (count_q != '0) & ~stall;
    // Redirect flushes, so a word acked in the same cycle is never kept.
    assign push           = (state_q == REQ) & ack & ~redirect_valid;
    assign count_after    = count_q + CW'(push) - CW'(pop);
    // count_after already includes the word landing this cycle, so a new
    // request is allowed only if a slot remains for it.
    assign can_issue      = count_after < CW'(FIFO_DEPTH);
    assign redirect_pc_al = {redirect_pc[31:2], 2'b00};
    assign unused_pc_lsb  = &{1'b0, redirect_pc[1:0]};

    assign imem.imem_req  = req_q;
    assign imem.imem_addr = addr_q;
    assign instr_valid    = (count_q != '0);
    assign instruction    = fifo_q[0].word;
    assign instr_pc       = fifo_q[0].pc;

    // Fetch control: next state, PC and registered request outputs.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_d      = req_q;
        addr_d     = addr_q;
        case (state_q)
            IDLE: begin
                if (redirect_valid) begin
                    fetch_pc_d = redirect_pc_al;
                end else if (can_issue) begin
                    state_d = REQ;
                    req_d   = 1'b1;
                    addr_d  = fetch_pc_q;
                end
            end
            REQ: begin
                if (redirect_valid) begin
                    fetch_pc_d = redirect_pc_al;
                    if (ack) begin
                        state_d = IDLE;
                        req_d   = 1'b0;
                    end else begin
                        // Request must stay up with its old address until acked.
                        state_d = DISCARD;
                    end
                end else if (ack) begin
                    fetch_pc_d = fetch_pc_q + 32'd4;
                    if (can_issue) begin
                        addr_d = fetch_pc_q + 32'd4;
                    end else begin
                        state_d = IDLE;
                        req_d   = 1'b0;
                    end
                end
            end
            DISCARD: begin
                if (redirect_valid) fetch_pc_d = redirect_pc_al;
                if (ack) begin
                    state_d = IDLE;
                    req_d   = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    // Prefetch FIFO as a shift queue so entry 0 is always the head register;
    // popping the last entry leaves it in place so outputs hold their value.
    always_comb begin
        fifo_d = fifo_q;
        if (pop && (count_q > CW'(1))) begin
            for (int i = 0; i < FIFO_DEPTH - 1; i++) fifo_d[i] = fifo_q[i + 1];
        end
        if (push) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                if (CW'(i) == (count_q - CW'(pop))) begin
                    fifo_d[i] = '{pc: fetch_pc_q, word: imem.imem_rdata};
                end
            end
        end
        count_d = redirect_valid ? '0 : count_after;
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            fetch_pc_q <= RESET_PC;
            req_q      <= 1'b0;
            addr_q     <= RESET_PC;
            count_q    <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_q      <= req_d;
            addr_q     <= addr_d;
            count_q    <= count_d;
            fifo_q     <= fifo_d;
        end
    end
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: a memory responder with configurable ack delay,
// directed steps in one initial block, and an expected-instruction queue that
// is compared whenever the classifier side consumes a word.
module tb_instr_fetch_unit;
    logic        clk = 1'b0;
    logic        rst;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        instr_valid;
    logic [31:0] instruction;
    logic [31:0] instr_pc;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;
    int n_pops  = 0;

    int ack_delay = 0;
    bit ack_force = 1'b0;
    int wait_cnt  = 0;

    logic [63:0] exp_q [$];

    instr_fetch_unit_if imem_if ();

    instr_fetch_unit #(.RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
        .clk            (clk),
        .rst            (rst),
        .imem           (imem_if.master),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .stall          (stall),
        .instr_valid    (instr_valid),
        .instruction    (instruction),
        .instr_pc       (instr_pc)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_stream(input logic [31:0] base, input int n);
        logic [31:0] pc;
        for (int i = 0; i < n; i++) begin
            pc = base + 32'(4 * i);
            exp_q.push_back({pc, pc + 32'hE000_0000});
        end
    endtask

    // Bounded wait for a request at a given address.
    task automatic wait_addr(input logic [31:0] a, input int max, input string tag);
        logic found;
        found = 1'b0;
        for (int i = 0; i < max; i++) begin
            if (imem_if.imem_req && imem_if.imem_addr == a) begin
                found = 1'b1;
                break;
            end
            tick(1);
        end
        check(tag, {31'b0, found}, 32'd1);
    endtask

    task automatic wait_valid(input int max, input string tag);
        logic found;
        found = 1'b0;
        for (int i = 0; i < max; i++) begin
            if (instr_valid) begin
                found = 1'b1;
                break;
            end
            tick(1);
        end
        check(tag, {31'b0, found}, 32'd1);
    endtask

    // Holds reset for two edges with a fresh expected stream from 0; reset
    // releases so the next edge is the first one with rst low.
    task automatic do_reset();
        rst = 1'b1;
        stall = 1'b0;
        redirect_valid = 1'b0;
        ack_force = 1'b0;
        tick(2);
        exp_q.delete();
        push_stream(32'h0, 40);
        rst = 1'b0;
    endtask

    // Memory model: answers each request after ack_delay waiting cycles with
    // rdata = addr + E000_0000; ack_force injects an unsolicited ack.
    always @(negedge clk) begin
        if (ack_force) begin
            imem_if.imem_ack   = 1'b1;
            imem_if.imem_rdata = 32'hDEAD_BEEF;
        end else if (imem_if.imem_req) begin
            if (wait_cnt >= ack_delay) begin
                imem_if.imem_ack   = 1'b1;
                imem_if.imem_rdata = imem_if.imem_addr + 32'hE000_0000;
                wait_cnt = 0;
            end else begin
                imem_if.imem_ack = 1'b0;
                wait_cnt++;
            end
        end else begin
            imem_if.imem_ack = 1'b0;
            wait_cnt = 0;
        end
    end

    // Consumer side: every word taken at the coming edge must be the next
    // expected one.
    always @(negedge clk) begin
        logic [63:0] e;
        if (!rst && instr_valid && !stall) begin
            n_total++;
            assert (exp_q.size() != 0) n_pass++;
            else begin
                n_fail++;
                $error("FAIL sb_unexpected: observed pc %h expected no output", instr_pc);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                n_pops++;
                check("sb_pc", instr_pc, e[63:32]);
                check("sb_instr", instruction, e[31:0]);
            end
        end
    end

    initial begin
        imem_if.imem_ack   = 1'b0;
        imem_if.imem_rdata = 32'h0;
        rst            = 1'b1;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        stall          = 1'b0;
        tick(2);

        // Reset state
        check("rst_req", {31'b0, imem_if.imem_req}, 32'd0);
        check("rst_addr", imem_if.imem_addr, 32'h0);
        check("rst_valid", {31'b0, instr_valid}, 32'd0);
        check("rst_instr", instruction, 32'h0);
        check("rst_pc", instr_pc, 32'h0);

        // Stream with ack every cycle
        do_reset();
        tick(1);
        check("s_req1", {31'b0, imem_if.imem_req}, 32'd1);
        check("s_addr0", imem_if.imem_addr, 32'h0);
        check("s_valid_lat", {31'b0, instr_valid}, 32'd0);
        tick(1);
        check("s_valid", {31'b0, instr_valid}, 32'd1);
        check("s_pc0", instr_pc, 32'h0);
        check("s_instr0", instruction, 32'hE000_0000);
        check("s_addr4", imem_if.imem_addr, 32'h4);
        for (int i = 0; i < 8; i++) begin
            tick(1);
            check("s_cont", {31'b0, instr_valid}, 32'd1);
        end

        // Backpressure: FIFO fills, request drops, head held
        do_reset();
        tick(2);
        stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick(1);
            check("bp_req", {31'b0, imem_if.imem_req}, 32'd0);
            check("bp_pc", instr_pc, 32'h0);
            check("bp_valid", {31'b0, instr_valid}, 32'd1);
        end
        stall = 1'b0;
        tick(10);

        // Redirect while a delayed request is outstanding
        ack_delay = 3;
        do_reset();
        exp_q.delete();
        tick(1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_1003;
        tick(1);
        redirect_valid = 1'b0;
        push_stream(32'h0000_1000, 40);
        check("dis_req", {31'b0, imem_if.imem_req}, 32'd1);
        check("dis_addr", imem_if.imem_addr, 32'h0);
        check("dis_valid", {31'b0, instr_valid}, 32'd0);
        wait_addr(32'h0000_1000, 20, "dis_new_addr");
        wait_valid(20, "dis_wait_valid");
        check("dis_first_pc", instr_pc, 32'h0000_1000);
        ack_delay = 0;
        tick(6);

        // Redirect coincident with ack and pop, one entry held
        do_reset();
        tick(5);
        check("co_pre_valid", {31'b0, instr_valid}, 32'd1);
        check("co_pre_req", {31'b0, imem_if.imem_req}, 32'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_2000;
        tick(1);
        redirect_valid = 1'b0;
        exp_q.delete();
        push_stream(32'h0000_2000, 40);
        check("co_flush", {31'b0, instr_valid}, 32'd0);
        check("co_idle", {31'b0, imem_if.imem_req}, 32'd0);
        tick(1);
        check("co_req", {31'b0, imem_if.imem_req}, 32'd1);
        check("co_addr", imem_if.imem_addr, 32'h0000_2000);
        tick(6);

        // PC wrap
        redirect_valid = 1'b1;
        redirect_pc    = 32'hFFFF_FFFC;
        tick(1);
        redirect_valid = 1'b0;
        exp_q.delete();
        push_stream(32'hFFFF_FFFC, 40);
        tick(1);
        check("wr_addr_top", imem_if.imem_addr, 32'hFFFF_FFFC);
        tick(1);
        check("wr_addr_zero", imem_if.imem_addr, 32'h0);
        check("wr_head_pc", instr_pc, 32'hFFFF_FFFC);
        tick(6);

        // Reset mid-request, stale ack after release
        ack_delay = 5;
        do_reset();
        tick(1);
        check("rm_req_pre", {31'b0, imem_if.imem_req}, 32'd1);
        rst = 1'b1;
        tick(1);
        check("rm_req", {31'b0, imem_if.imem_req}, 32'd0);
        check("rm_valid", {31'b0, instr_valid}, 32'd0);
        check("rm_addr", imem_if.imem_addr, 32'h0);
        exp_q.delete();
        push_stream(32'h0, 40);
        rst = 1'b0;
        ack_force = 1'b1;
        tick(1);
        ack_force = 1'b0;
        ack_delay = 0;
        check("rm_stale_valid", {31'b0, instr_valid}, 32'd0);
        check("rm_restart_req", {31'b0, imem_if.imem_req}, 32'd1);
        check("rm_restart_addr", imem_if.imem_addr, 32'h0);
        wait_valid(10, "rm_wait_valid");
        check("rm_first_pc", instr_pc, 32'h0);
        tick(6);

        stall = 1'b1;
        tick(2);
        check("sb_enough_pops", {31'b0, (n_pops >= 20)}, 32'd1);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
Instruction fetch stage directly upstream of the instruction classifier. It keeps the fetch PC and issues word reads to instruction memory over a req/ack handshake. Returned words go into a small prefetch FIFO, whose head drives instruction/instr_valid into the classifier. Branch redirects flush the FIFO and restart fetch at a new PC.

Parameters:
RESET_PC, 32'h0000_0000, fetch PC loaded on reset (bits [1:0] must be 0)
FIFO_DEPTH, 2, prefetch FIFO entries (power of two, >= 2)

Ports:
clk  input  1  clock, all state on rising edge
rst  input  1  synchronous reset, active-high
imem_req  output  1  memory read request, registered
imem_addr  output  32  word address of request, bits [1:0] always 0
imem_ack  input  1  memory completes current request; imem_rdata valid this cycle
imem_rdata  input  32  fetched instruction word
redirect_valid  input  1  branch/exception redirect, single-cycle pulse
redirect_pc  input  32  new fetch PC; bits [1:0] ignored (forced 0)
stall  input  1  downstream not consuming; head entry held
instr_valid  output  1  FIFO non-empty; instruction/instr_pc valid
instruction  output  32  head instruction word to classifier
instr_pc  output  32  address of head instruction

Behaviour:
- Reset, checked at clk edge with rst=1, overrides all inputs. Effects: fetch_pc=RESET_PC; state=IDLE; FIFO empty; imem_req=0; imem_addr=RESET_PC; instr_valid=0; instruction=0; instr_pc=0.
- Reset mid-request abandons the transaction. An imem_ack arriving after reset, while imem_req=0, is ignored.
- At most one memory request is outstanding.
- Request handshake: imem_req and imem_addr are held stable until the cycle in which imem_ack=1. The transfer completes that cycle. imem_ack while imem_req=0 is ignored.
- Issue condition: the FIFO count plus the outstanding request must be below FIFO_DEPTH. The FIFO therefore never overflows.
- States:
  - IDLE: imem_req=0. If the issue condition holds and there is no redirect, go to REQ next cycle with imem_addr=fetch_pc.
  - REQ: on imem_ack, push {fetch_pc, imem_rdata} and set fetch_pc += 4 (wraps mod 2^32). If the issue condition still holds after the push and pop, stay in REQ with imem_addr=new fetch_pc (back-to-back). Otherwise go to IDLE.
  - DISCARD: entered on a redirect while a request is outstanding without ack that cycle. imem_req stays high with the old address. On imem_ack the data is dropped and the state goes to IDLE. No push.
- Redirect (redirect_valid=1):
  - FIFO flushed at the edge: instr_valid=0 next cycle.
  - fetch_pc = {redirect_pc[31:2], 2'b00}.
  - From IDLE: go to IDLE; the request issues the following cycle.
  - From REQ without ack: go to DISCARD.
  - From REQ with ack the same cycle: data dropped, go to IDLE.
  - From DISCARD: fetch_pc updated, stay in DISCARD.
- Pop: occurs when instr_valid=1 and stall=0 at the edge.
- Simultaneous push and pop: count unchanged, order preserved.
- Simultaneous redirect and pop, or redirect and push: the flush wins and nothing is retained.
- Latency:
  - Reset release to first imem_req: 1 cycle.
  - ack at edge N to instr_valid=1: visible after edge N.
  - Redirect at edge N to new imem_req with the new address: visible after edge N+1 when previously IDLE or acked that cycle. Otherwise one cycle after the discard ack.
- Outputs instruction/instr_pc come straight from FIFO head registers (no combinational path from imem_rdata). They hold their last value while instr_valid=0.

Test Plan:
- Reset then stream: RESET_PC=0; imem_ack=1 every cycle while imem_req; rdata=addr+32'hE000_0000; stall=0 -> imem_addr 0,4,8,...; instr_valid continuous from cycle 2; instruction=E000_0000, E000_0004, ...; instr_pc matches.
- Backpressure: stall=1 from cycle 3, ack always 1 -> FIFO fills to 2; imem_req drops to 0; instr_pc held at 0; release stall -> instr_pc 0,4,8 in order with no loss or duplicate.
- Redirect with outstanding request: ack delayed 3 cycles; redirect_pc=32'h0000_1003 pulsed while REQ -> DISCARD; returned word never appears; next imem_addr=32'h0000_1000; first valid instr_pc=32'h0000_1000.
- Redirect coincident with ack and pop: FIFO holding 1 entry -> instr_valid=0 next cycle; acked word dropped; next imem_addr=redirect_pc.
- PC wrap: redirect_pc=32'hFFFF_FFFC; ack always -> addresses FFFF_FFFC, then 0000_0000.
- Reset mid-request: rst=1 while imem_req=1, ack arriving after reset -> imem_req=0, instr_valid=0, stale ack ignored; fetch restarts at RESET_PC.
